// File: rtl/ir_packet_scheduler.sv
// rtl/ir_packet_scheduler.sv - periodic IR packet scheduler with command safety timeout
// Define IR_WRITE_TRIGGER_EN to let a changed CMD write fire an early, gap-limited packet.
module ir_packet_scheduler #(
   parameter int         CLK_FREQ_HZ     = 100_000_000,
   parameter int         PACKET_RATE_HZ  = 10,
   parameter int         CMD_LEN         = 4,
   parameter logic [7:0] BASE_ADDR       = 8'h90,
   parameter int         TIMEOUT_PACKETS = 20,
   parameter int         MIN_GAP_CYCLES  = (CLK_FREQ_HZ / PACKET_RATE_HZ) / 2
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [7:0]         BUS_ADDR,
   input  logic [7:0]         BUS_DATA_IN,
   input  logic               BUS_WE,
   output logic [7:0]         BUS_DATA_OUT,
   output logic [CMD_LEN-1:0] COMMAND,
   output logic               SEND_PACKET,
   output logic               TIMED_OUT
);
   localparam int PERIOD = CLK_FREQ_HZ / PACKET_RATE_HZ;
   localparam int PCW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int KCW    = $clog2(TIMEOUT_PACKETS + 1);
   localparam logic [PCW-1:0] PERIOD_LAST  = PCW'(PERIOD - 1);
   localparam logic [KCW-1:0] TIMEOUT_MAX  = KCW'(TIMEOUT_PACKETS);
   localparam logic [KCW-1:0] TIMEOUT_LAST = KCW'(TIMEOUT_PACKETS - 1);
   localparam logic [7:0]     CTRL_ADDR    = BASE_ADDR + 8'd1;

   typedef enum logic [1:0] {IDLE, WAIT, FIRE} state_t;

   state_t             state, state_next;
   logic [PCW-1:0]     period_cnt, period_cnt_next;
   logic [KCW-1:0]     packet_cnt;
   logic [CMD_LEN-1:0] pending;
   logic               enable;
   logic               cmd_wr, ctrl_wr, fire_entry, trigger_fire;
   logic               data_unused;

   assign cmd_wr      = BUS_WE && (BUS_ADDR == BASE_ADDR);
   assign ctrl_wr     = BUS_WE && (BUS_ADDR == CTRL_ADDR);
   assign data_unused = ^BUS_DATA_IN;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= IDLE;
         period_cnt <= '0;
      end else begin
         state      <= state_next;
         period_cnt <= period_cnt_next;
      end
   end

   // Disable wins over a period expiry; a FIRE already entered always completes.
   always_comb begin
      state_next      = state;
      period_cnt_next = period_cnt;
      case (state)
         IDLE: begin
            period_cnt_next = '0;
            if (enable) state_next = WAIT;
         end
         WAIT: begin
            if (!enable) begin
               state_next      = IDLE;
               period_cnt_next = '0;
            end else if ((period_cnt == PERIOD_LAST) || trigger_fire) begin
               state_next      = FIRE;
               period_cnt_next = '0;
            end else begin
               period_cnt_next = period_cnt + 1'b1;
            end
         end
         FIRE: begin
            state_next      = WAIT;
            period_cnt_next = '0;
         end
         default: begin
            state_next      = IDLE;
            period_cnt_next = '0;
         end
      endcase
   end

   assign fire_entry = (state_next == FIRE);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pending     <= '0;
         enable      <= 1'b0;
         COMMAND     <= '0;
         SEND_PACKET <= 1'b0;
         TIMED_OUT   <= 1'b0;
         packet_cnt  <= '0;
      end else begin
         SEND_PACKET <= fire_entry;
         if (ctrl_wr) enable <= BUS_DATA_IN[0];
         if (fire_entry) COMMAND <= TIMED_OUT ? '0 : pending;
         // A CMD write on the same edge as the saturating FIRE keeps the car running.
         if (cmd_wr) begin
            pending    <= BUS_DATA_IN[CMD_LEN-1:0];
            packet_cnt <= '0;
            TIMED_OUT  <= 1'b0;
         end else if (fire_entry && (packet_cnt != TIMEOUT_MAX)) begin
            packet_cnt <= packet_cnt + 1'b1;
            if (packet_cnt == TIMEOUT_LAST) begin
               TIMED_OUT <= 1'b1;
               pending   <= '0;
            end
         end
      end
   end

`ifdef IR_WRITE_TRIGGER_EN
   localparam int GCW = $clog2(MIN_GAP_CYCLES + 1);
   localparam logic [GCW-1:0] GAP_LAST = GCW'(MIN_GAP_CYCLES - 1);

   logic [GCW-1:0] gap_cnt;
   logic           trig_req;

   assign trigger_fire = trig_req && (gap_cnt >= GAP_LAST);

   // gap_cnt counts edges since the last FIRE entry; saturated means the gap is met.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         gap_cnt  <= GAP_LAST;
         trig_req <= 1'b0;
      end else begin
         if (fire_entry) gap_cnt <= '0;
         else if (gap_cnt < GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
         if (fire_entry || !enable) trig_req <= 1'b0;
         if (cmd_wr && enable && (BUS_DATA_IN[CMD_LEN-1:0] != pending)) trig_req <= 1'b1;
      end
   end
`else
   localparam int MIN_GAP_UNUSED = MIN_GAP_CYCLES;
   assign trigger_fire = 1'b0;
`endif

   always_comb begin
      BUS_DATA_OUT = 8'h00;
      if (BUS_ADDR == BASE_ADDR) BUS_DATA_OUT = 8'(pending);
      else if (BUS_ADDR == CTRL_ADDR) BUS_DATA_OUT = {6'b0, TIMED_OUT, enable};
   end

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// tb/tb_ir_packet_scheduler.sv - directed bench for ir_packet_scheduler (PERIOD=10, timeout 3, gap 4)
module tb_ir_packet_scheduler;
   localparam logic [7:0] CMD_ADDR  = 8'h90;
   localparam logic [7:0] CTRL_ADDR = 8'h91;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] BUS_ADDR = 8'h00;
   logic [7:0] BUS_DATA_IN = 8'h00;
   logic       BUS_WE = 1'b0;
   logic [7:0] BUS_DATA_OUT;
   logic [3:0] COMMAND;
   logic       SEND_PACKET;
   logic       TIMED_OUT;

   int checks = 0;
   int failures = 0;
   int edge_n = 0;
   int pulse_cnt = 0;
   int e0, r, wr, snap, last_pulse, last_cmd;
   logic [7:0] rd;

   ir_packet_scheduler #(
      .CLK_FREQ_HZ(1000), .PACKET_RATE_HZ(100), .CMD_LEN(4),
      .BASE_ADDR(8'h90), .TIMEOUT_PACKETS(3), .MIN_GAP_CYCLES(4)
   ) dut (
      .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA_IN(BUS_DATA_IN),
      .BUS_WE(BUS_WE), .BUS_DATA_OUT(BUS_DATA_OUT), .COMMAND(COMMAND),
      .SEND_PACKET(SEND_PACKET), .TIMED_OUT(TIMED_OUT)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) edge_n++;
   always @(negedge CLK) if (SEND_PACKET === 1'b1) pulse_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic goto(input int e);
      while (edge_n < e) @(negedge CLK);
   endtask

   task automatic bus_write(input logic [7:0] addr, input logic [7:0] data, output int wr_edge);
      wr_edge     = edge_n + 1;
      BUS_ADDR    = addr;
      BUS_DATA_IN = data;
      BUS_WE      = 1'b1;
      @(negedge CLK);
      BUS_WE      = 1'b0;
   endtask

   task automatic read_reg(input logic [7:0] addr, output logic [7:0] d);
      BUS_ADDR = addr;
      #1;
      d = BUS_DATA_OUT;
   endtask

   task automatic expect_pulse(input string tag, input int e, input int cmd);
      goto(e - 1);
      check({tag, "_pre_send"}, SEND_PACKET, 0);
      goto(e);
      check({tag, "_send"}, SEND_PACKET, 1);
      check({tag, "_command"}, COMMAND, cmd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      goto(2);
      check("rst_command", COMMAND, 0);
      check("rst_send", SEND_PACKET, 0);
      check("rst_timed_out", TIMED_OUT, 0);
      read_reg(CMD_ADDR, rd);  check("rst_cmd_reg", rd, 8'h00);
      read_reg(CTRL_ADDR, rd); check("rst_ctrl_reg", rd, 8'h00);
      read_reg(8'h92, rd);     check("rst_foreign_addr", rd, 8'h00);
      RESET = 1'b0;
      goto(4);

      // upper data bits are dropped: pending becomes 4'b1001
      bus_write(CMD_ADDR, 8'hF9, wr);
      bus_write(CTRL_ADDR, 8'h01, e0);
      read_reg(CMD_ADDR, rd); check("cmd_reg_masked", rd, 8'h09);
      goto(e0 + 10);
      check("first_pre_command", COMMAND, 0);
      expect_pulse("p1", e0 + 11, 9);
      goto(e0 + 12);
      check("p1_one_cycle", SEND_PACKET, 0);
      expect_pulse("p2", e0 + 22, 9);
      expect_pulse("p3", e0 + 33, 9);
      check("p3_timed_out", TIMED_OUT, 1);
      read_reg(CTRL_ADDR, rd); check("timeout_ctrl_reg", rd, 8'h03);
      read_reg(CMD_ADDR, rd);  check("timeout_cmd_reg", rd, 8'h00);
      expect_pulse("p4_stopped", e0 + 44, 0);

`ifndef IR_WRITE_TRIGGER_EN
      goto(e0 + 45);
      bus_write(CMD_ADDR, 8'h02, wr);
      check("clear_timed_out", TIMED_OUT, 0);
      read_reg(CTRL_ADDR, rd); check("clear_ctrl_reg", rd, 8'h01);
      expect_pulse("p5_resumed", e0 + 55, 2);
      goto(e0 + 65);
      bus_write(CMD_ADDR, 8'h06, wr);
      check("fire_edge_write_edge", wr, e0 + 66);
      check("p6_old_value", COMMAND, 2);
      check("p6_send", SEND_PACKET, 1);
      expect_pulse("p7_new_value", e0 + 77, 6);
      expect_pulse("p8", e0 + 88, 6);
      goto(e0 + 98);
      bus_write(CMD_ADDR, 8'h05, wr);
      check("sat_fire_send", SEND_PACKET, 1);
      check("sat_fire_command", COMMAND, 6);
      check("sat_write_wins", TIMED_OUT, 0);
      goto(e0 + 100);
      check("sat_write_wins_later", TIMED_OUT, 0);
      read_reg(CMD_ADDR, rd); check("sat_write_kept", rd, 8'h05);
      expect_pulse("p10", e0 + 110, 5);
      last_pulse = e0 + 110;
      last_cmd   = 5;
`else
      goto(e0 + 45);
      bus_write(CMD_ADDR, 8'h02, wr);
      check("trig_clear_timed_out", TIMED_OUT, 0);
      goto(e0 + 47);
      check("trig_gap_hold", SEND_PACKET, 0);
      expect_pulse("trig_fire", e0 + 48, 2);
      expect_pulse("trig_periodic", e0 + 59, 2);
      goto(e0 + 64);
      bus_write(CMD_ADDR, 8'h02, wr);
      goto(e0 + 66);
      check("trig_same_data_no_fire", SEND_PACKET, 0);
      expect_pulse("trig_periodic2", e0 + 70, 2);
      last_pulse = e0 + 70;
      last_cmd   = 2;
`endif

      goto(last_pulse + 4);
      bus_write(CTRL_ADDR, 8'h00, wr);
      snap = pulse_cnt;
      goto(last_pulse + 40);
      check("disabled_no_pulse", pulse_cnt - snap, 0);
      check("disabled_command_held", COMMAND, last_cmd);
      read_reg(CTRL_ADDR, rd); check("disabled_ctrl_reg", rd, 8'h00);
      bus_write(CTRL_ADDR, 8'h01, r);
      expect_pulse("reenable", r + 11, last_cmd);
      expect_pulse("pre_reset", r + 22, last_cmd);
      check("pre_reset_timed_out", TIMED_OUT, 1);

      #2 RESET = 1'b1;
      #1;
      check("async_rst_send", SEND_PACKET, 0);
      check("async_rst_command", COMMAND, 0);
      check("async_rst_timed_out", TIMED_OUT, 0);
      read_reg(CTRL_ADDR, rd); check("async_rst_ctrl_reg", rd, 8'h00);
      @(negedge CLK);
      RESET = 1'b0;
      snap = pulse_cnt;
      goto(r + 45);
      check("post_reset_idle", pulse_cnt - snap, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
